// File: rtl/maze_renderer.sv
// maze_renderer
//   Pixel-colour stage placed after display_controller. Holds a writable
//   20x15 wall map of 32x32-pixel tiles and the player's tile position, and
//   renders a 2-stage pixel pipeline onto a 12-bit rgb bus. Move requests
//   are resolved only at the frame boundary, so a frame never shows a
//   half-updated player.
//
//   Ports
//     clk        system clock
//     reset      synchronous, active-high
//     hCount     horizontal counter (10b)
//     vCount     vertical counter (10b)
//     bright     visible-area flag
//     rgb        pixel colour {R,G,B} (12b), 2 cycles after hCount/vCount
//     wall_we    wall-row write strobe
//     wall_row   row index 0..14 (15 ignored)
//     wall_data  wall bits, bit i = column i
//     move_req   move request, taken while idle
//     move_dir   00 up, 01 down, 10 left, 11 right
//     move_busy  a move is pending
//     move_done  one-cycle pulse when the pending move resolves
//     move_ok    move applied (valid with move_done, held until the next)
//     player_x   player column (5b)
//     player_y   player row (4b)
//     win        sticky, set once the player sits on the goal tile
//
//   Move FSM
//     state | meaning
//     IDLE  | waiting for move_req
//     PEND  | direction latched, waiting for frame_tick to resolve
module maze_renderer #(
    parameter int H_START = 144,
    parameter int V_START = 35,
    parameter int START_X = 1,
    parameter int START_Y = 1,
    parameter int GOAL_X  = 18,
    parameter int GOAL_Y  = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic        bright,
    output logic [11:0] rgb,
    input  logic        wall_we,
    input  logic [3:0]  wall_row,
    input  logic [19:0] wall_data,
    input  logic        move_req,
    input  logic [1:0]  move_dir,
    output logic        move_busy,
    output logic        move_done,
    output logic        move_ok,
    output logic [4:0]  player_x,
    output logic [3:0]  player_y,
    output logic        win
);

    localparam logic [9:0] H_ST   = 10'(H_START);
    localparam logic [9:0] V_ST   = 10'(V_START);
    localparam logic [9:0] V_TICK = 10'(V_START + 480);
    localparam logic [4:0] ST_X   = 5'(START_X);
    localparam logic [3:0] ST_Y   = 4'(START_Y);
    localparam logic [4:0] GL_X   = 5'(GOAL_X);
    localparam logic [3:0] GL_Y   = 4'(GOAL_Y);

    typedef enum logic {IDLE, PEND} state_t;

    state_t      state;
    logic [1:0]  pend_dir;
    logic [19:0] wall_map [0:14];

    // ---------------- wall map ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 15; r++)
                wall_map[r] <= (r == 0 || r == 14) ? 20'hFFFFF : 20'h80001;
        end else if (wall_we && wall_row <= 4'd14) begin
            wall_map[wall_row] <= wall_data;
        end
    end

    // ---------------- pixel pipeline ----------------
    logic [9:0] px, py;
    logic [4:0] col_c;
    logic [3:0] row_c;

    assign px    = hCount - H_ST;
    assign py    = vCount - V_ST;
    assign col_c = px[9:5];
    assign row_c = py[8:5];

    logic [4:0] s1_col;
    logic [3:0] s1_row;
    logic [4:0] s1_ox, s1_oy;
    logic       s1_wall;
    logic       s1_bright;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_col    <= '0;
            s1_row    <= '0;
            s1_ox     <= '0;
            s1_oy     <= '0;
            s1_wall   <= 1'b0;
            s1_bright <= 1'b0;
        end else begin
            s1_col    <= col_c;
            s1_row    <= row_c;
            s1_ox     <= px[4:0];
            s1_oy     <= py[4:0];
            // out-of-grid tiles are blanked in stage 2, so the bit is a don't-care
            s1_wall   <= (col_c <= 5'd19 && row_c <= 4'd14) ? wall_map[row_c][col_c] : 1'b0;
            s1_bright <= bright;
        end
    end

    logic in_marker;
    assign in_marker = (s1_ox >= 5'd4) && (s1_ox <= 5'd27) &&
                       (s1_oy >= 5'd4) && (s1_oy <= 5'd27);

    always_ff @(posedge clk) begin
        if (reset)
            rgb <= 12'h000;
        else if (!s1_bright || s1_col > 5'd19 || s1_row > 4'd14)
            rgb <= 12'h000;
        else if (s1_col == player_x && s1_row == player_y && in_marker)
            rgb <= 12'hF00;
        else if (s1_col == GL_X && s1_row == GL_Y)
            rgb <= 12'h0F0;
        else if (s1_wall)
            rgb <= 12'h00F;
        else
            rgb <= 12'hFFF;
    end

    // ---------------- frame tick ----------------
    // Counters may dwell on the tick position for several clk cycles;
    // edge-detect so the strobe is one cycle per frame.
    logic tick_cond, tick_cond_d, frame_tick;
    assign tick_cond  = (hCount == 10'd0) && (vCount == V_TICK);
    assign frame_tick = tick_cond && !tick_cond_d;

    always_ff @(posedge clk) begin
        if (reset)
            tick_cond_d <= 1'b0;
        else
            tick_cond_d <= tick_cond;
    end

    // ---------------- move target ----------------
    logic [4:0] tgt_x;
    logic [3:0] tgt_y;
    logic       off_grid;
    logic       tgt_wall;
    logic       move_accept;

    always_comb begin
        tgt_x    = player_x;
        tgt_y    = player_y;
        off_grid = 1'b0;
        case (pend_dir)
            2'b00: if (player_y == 4'd0)  off_grid = 1'b1; else tgt_y = player_y - 4'd1;
            2'b01: if (player_y == 4'd14) off_grid = 1'b1; else tgt_y = player_y + 4'd1;
            2'b10: if (player_x == 5'd0)  off_grid = 1'b1; else tgt_x = player_x - 5'd1;
            default: if (player_x == 5'd19) off_grid = 1'b1; else tgt_x = player_x + 5'd1;
        endcase
        tgt_wall    = (!off_grid && tgt_x <= 5'd19 && tgt_y <= 4'd14) ? wall_map[tgt_y][tgt_x] : 1'b0;
        move_accept = !off_grid && !tgt_wall;
    end

    // ---------------- move FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pend_dir  <= 2'b00;
            player_x  <= ST_X;
            player_y  <= ST_Y;
            move_done <= 1'b0;
            move_ok   <= 1'b0;
            move_busy <= 1'b0;
            win       <= 1'b0;
        end else begin
            move_done <= 1'b0;
            // win follows the registered position, so it lands one edge after the move
            if (player_x == GL_X && player_y == GL_Y)
                win <= 1'b1;
            case (state)
                IDLE: begin
                    if (move_req) begin
                        pend_dir  <= move_dir;
                        state     <= PEND;
                        move_busy <= 1'b1;
                    end
                end
                PEND: begin
                    if (frame_tick) begin
                        if (move_accept) begin
                            player_x <= tgt_x;
                            player_y <= tgt_y;
                        end
                        move_ok   <= move_accept;
                        move_done <= 1'b1;
                        move_busy <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    move_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
